// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES GF(2^8) helpers, FSM state type and block geometry
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_COL_W = 32;
  localparam int AES_NCOL  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    DONE = 2'd2
  } fsm_state_t;

  // Multiply by x modulo 0x11B.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

endpackage

// File: rtl/mix_single_column.sv
// rtl/mix_single_column.sv - combinational forward MixColumns of one 32-bit column
module mix_single_column
  import aes_pkg::*;
(
  input  logic [AES_COL_W-1:0] i_col,
  output logic [AES_COL_W-1:0] o_col
);

  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  assign o_col[31:24] = xtime(w_a0) ^ gf_mul3(w_a1) ^ w_a2 ^ w_a3;
  assign o_col[23:16] = w_a0 ^ xtime(w_a1) ^ gf_mul3(w_a2) ^ w_a3;
  assign o_col[15:8]  = w_a0 ^ w_a1 ^ xtime(w_a2) ^ gf_mul3(w_a3);
  assign o_col[7:0]   = gf_mul3(w_a0) ^ w_a1 ^ w_a2 ^ xtime(w_a3);

endmodule

// File: rtl/mix_col_engine.sv
// rtl/mix_col_engine.sv - iterative AES MixColumns engine; optional MIX_COL_BYPASS_EN adds last_round bypass
module mix_col_engine
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AES_BLK_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
`ifdef MIX_COL_BYPASS_EN
  input  logic                 last_round,
`endif
  output logic [AES_BLK_W-1:0] out_data
);

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE % AES_NCOL);
  localparam logic [1:0] LAST_CNT = 2'(AES_NCOL - COLS_PER_CYCLE);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
      $error("mix_col_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  fsm_state_t           r_state, w_state_next;
  logic [1:0]           r_col_cnt;
  logic [AES_BLK_W-1:0] r_work;
  logic [AES_BLK_W-1:0] w_work_mix;
  logic                 w_in_hs;
  logic                 w_bypass;
  logic [6:0]           w_hi      [COLS_PER_CYCLE];
  logic [AES_COL_W-1:0] w_col_out [COLS_PER_CYCLE];

`ifdef MIX_COL_BYPASS_EN
  assign w_bypass = last_round;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_in_hs = in_valid && in_ready;

  // Groups are aligned to COLS_PER_CYCLE, so col_cnt+g never wraps within a group.
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    logic [1:0] w_idx;
    assign w_idx    = r_col_cnt + 2'(g);
    assign w_hi[g]  = 7'd127 - {w_idx, 5'd0};
    mix_single_column u_mix (
      .i_col (r_work[w_hi[g] -: AES_COL_W]),
      .o_col (w_col_out[g])
    );
  end

  always_comb begin
    w_work_mix = r_work;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      w_work_mix[w_hi[g] -: AES_COL_W] = w_col_out[g];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_in_hs) w_state_next = w_bypass ? DONE : MIX;
      MIX:     if (r_col_cnt == LAST_CNT) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE) && !rst;
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_work    <= '0;
      r_col_cnt <= 2'd0;
    end else if (r_state == IDLE && w_in_hs) begin
      r_work    <= in_data;
      r_col_cnt <= 2'd0;
    end else if (r_state == MIX) begin
      r_work    <= w_work_mix;
      r_col_cnt <= r_col_cnt + STEP;
    end
  end

  assign out_data = r_work;

endmodule
